ram_io_responder: RTL
=====================

// Module: ram_io_responder
// PURPOSE
// Responder end of the byte-serial memory bus driven by the memory controller: services one byte per cycle
// from a byte-addressed RAM, or from a memory-mapped I/O window. The I/O window holds a UART TX FIFO, a UART RX FIFO
// and a program-end register. It reports TX back-pressure to the initiator on io_buffer_full.
// PARAMETERS
// RAM_AW    17  RAM address width; RAM depth = 2**RAM_AW bytes
// TX_DEPTH  8   TX FIFO entries (power of 2, >=4)
// RX_DEPTH  8   RX FIFO entries (power of 2, >=2)
// TX_GAP    4   minimum cycles from one TX handshake to the next tx_valid assertion
// PORTS
// clk             in   1   clock, rising edge
// rst             in   1   reset, synchronous, active-high
// rdy             in   1   when low, bus-side actions are ignored; TX/RX sides keep running
// mem_wr          in   1   1 = write, 0 = read
// mem_a           in   32  byte address
// mem_din         in   8   write data
// mem_dout        out  8   read data, registered
// io_buffer_full  out  1   TX FIFO almost full
// tx_byte         out  8   byte to UART transmitter
// tx_valid        out  1   tx_byte valid
// tx_ready        in   1   UART accepts tx_byte
// rx_byte         in   8   byte from UART receiver
// rx_valid        in   1   rx_byte valid
// rx_ready        out  1   RX FIFO can accept
// prog_end        out  1   sticky; program wrote the end register
// drop_cnt        out  8   saturating count of TX bytes dropped on full FIFO
// BEHAVIOUR
// - Decode rule: io = (mem_a[17:16]==2'b11).
//   - RAM index = mem_a[RAM_AW-1:0].
//   - IO regs: 0x30000 = UART data; 0x30004 = control/status. Compare on mem_a[17:0].
//   - Other IO addresses: writes ignored, reads return 0.
// - Read latency is 1 cycle. An address sampled at edge N with mem_wr=0 and rdy=1 drives mem_dout after edge N.
//   - mem_dout holds its value when rdy=0 and on write cycles.
//   - A back-to-back address stream yields one byte per cycle.
// - RAM write: at each edge with mem_wr=1, rdy=1 and !io, the RAM takes ram[idx] <= mem_din.
//   - RAM contents are not reset.
// - IO write to 0x30000: pushes mem_din into the TX FIFO.
//   - If the FIFO is full, the byte is dropped and drop_cnt increments, saturating at 0xFF.
// - IO write to 0x30004: sets prog_end=1. It stays set until rst.
// - IO read of 0x30000: pops the RX FIFO head into mem_dout. If the FIFO is empty, mem_dout=0x00 and nothing pops.
//   - Every qualifying cycle pops once. The initiator presents this address for exactly one read cycle.
// - IO read of 0x30004: mem_dout = {6'b0, rx_count!=0, tx_count==TX_DEPTH}.
// - io_buffer_full = (tx_count >= TX_DEPTH-1), registered from the post-update count.
//   - The extra slot absorbs the one write the initiator issues before it sees the flag.
// - TX drain:
//   - tx_valid=1 when the FIFO is non-empty and gap_cnt==0; tx_byte is the FIFO head.
//   - On the handshake (tx_valid & tx_ready): pop the head and load gap_cnt=TX_GAP-1.
//   - gap_cnt then decrements by 1 per cycle down to 0.
//   - tx_byte/tx_valid stay stable while tx_ready=0.
// - RX fill: rx_ready = !rst && rx_count<RX_DEPTH. Push rx_byte on rx_valid & rx_ready.
// - Simultaneous push and pop on the same FIFO:
//   - Both complete and the count is unchanged.
//   - On a full TX FIFO, a bus write in the same cycle as a drain pop is accepted.
//   - On an empty RX FIFO, a bus read in the same cycle as an rx push returns 0x00; the new byte stays queued.
// - Pointers are log2(DEPTH) bits and wrap naturally. Counts are log2(DEPTH)+1 bits, so full is distinguishable from empty.
// - Reset (including mid-transfer):
//   - mem_dout=0, io_buffer_full=0, tx_valid=0, prog_end=0, drop_cnt=0, rx_ready=0 during rst.
//   - FIFOs emptied, gap_cnt=0. Any in-flight handshake is discarded.
// TESTING
// - RAM: write 0xA5 to 0x00100, then read 0x00100..0x00103 on consecutive cycles
//   -> 0xA5 appears on mem_dout exactly one cycle after the first address, then subsequent bytes follow one per cycle.
// - TX back-pressure: tx_ready=0; write 0x41..0x49 (9 bytes) to 0x30000
//   -> io_buffer_full rises after the 7th byte; the 9th byte is dropped and drop_cnt=1.
// - TX drain: tx_ready=1 with 3 bytes queued -> handshakes at cycles t, t+4, t+8; bytes 0x41,0x42,0x43 in order.
// - RX: push 0x10,0x20; read 0x30000 three times -> 0x10, 0x20, 0x00. Read 0x30004 before the first pop -> 0x02.
// - Simultaneous ops: TX FIFO full while tx_ready pops and a bus write lands in the same cycle -> byte accepted, drop_cnt unchanged.
//   prog_end: write 0x30004 -> prog_end=1 and it stays set.
// - Reset mid-operation: rst for 1 cycle with 5 TX bytes queued -> tx_valid=0, io_buffer_full=0, prog_end=0;
//   a following read of 0x30000 returns 0x00.

Source files
------------

// File: rtl/ram_io_responder_if.sv
// Byte-serial memory bus between the memory controller (master) and the RAM/IO responder (slave),
// together with the UART-side TX/RX streams and the responder's status outputs.
interface ram_io_responder_if;
    logic        rdy;
    logic        mem_wr;
    logic [31:0] mem_a;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic        io_buffer_full;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_ready;
    logic        prog_end;
    logic [7:0]  drop_cnt;

    modport master (
        output rdy, mem_wr, mem_a, mem_din, tx_ready, rx_byte, rx_valid,
        input  mem_dout, io_buffer_full, tx_byte, tx_valid, rx_ready, prog_end, drop_cnt
    );

    modport slave (
        input  rdy, mem_wr, mem_a, mem_din, tx_ready, rx_byte, rx_valid,
        output mem_dout, io_buffer_full, tx_byte, tx_valid, rx_ready, prog_end, drop_cnt
    );
endinterface

// File: rtl/ram_io_responder.sv
// Memory-bus responder: byte-addressed RAM plus an I/O window with UART TX/RX FIFOs,
// a paced TX drain, a sticky program-end flag and a saturating TX drop counter.
module ram_io_responder #(
    parameter int RAM_AW   = 17,
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8,
    parameter int TX_GAP   = 4
) (
    input  logic              clk,
    input  logic              rst,
    ram_io_responder_if.slave bus
);
    localparam int TX_PW = $clog2(TX_DEPTH);
    localparam int RX_PW = $clog2(RX_DEPTH);
    localparam int TX_CW = TX_PW + 1;
    localparam int RX_CW = RX_PW + 1;
    localparam int GW    = $clog2(TX_GAP + 1);

    localparam logic [TX_CW-1:0] TX_FULL   = TX_CW'(TX_DEPTH);
    localparam logic [TX_CW-1:0] TX_ALMOST = TX_CW'(TX_DEPTH - 1);
    localparam logic [RX_CW-1:0] RX_FULL   = RX_CW'(RX_DEPTH);
    localparam logic [GW-1:0]    GAP_LOAD  = GW'(TX_GAP - 1);

    logic [7:0] ram    [2**RAM_AW];
    logic [7:0] tx_mem [TX_DEPTH];
    logic [7:0] rx_mem [RX_DEPTH];

    logic [TX_PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [RX_PW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [TX_CW-1:0] tx_count_q, tx_count_d;
    logic [RX_CW-1:0] rx_count_q, rx_count_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [7:0]       mem_dout_q, mem_dout_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic             prog_end_q, prog_end_d;
    logic             io_full_q, io_full_d;

    logic              is_io, sel_data, sel_ctrl, bus_rd, bus_wr;
    logic              tx_valid, tx_pop, tx_push, rx_ready, rx_push, rx_pop;
    logic [RAM_AW-1:0] ram_idx;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^bus.mem_a[31:18];

    always_comb begin
        is_io    = bus.mem_a[17:16] == 2'b11;
        sel_data = is_io && (bus.mem_a[17:0] == 18'h30000);
        sel_ctrl = is_io && (bus.mem_a[17:0] == 18'h30004);
        bus_rd   = bus.rdy && !bus.mem_wr;
        bus_wr   = bus.rdy && bus.mem_wr;
        ram_idx  = bus.mem_a[RAM_AW-1:0];

        tx_valid = !rst && (tx_count_q != '0) && (gap_cnt_q == '0);
        tx_pop   = tx_valid && bus.tx_ready;
        // A drain pop in the same cycle frees the slot a full-FIFO write needs
        tx_push  = bus_wr && sel_data && ((tx_count_q != TX_FULL) || tx_pop);
        rx_ready = !rst && (rx_count_q != RX_FULL);
        rx_push  = rx_ready && bus.rx_valid;
        rx_pop   = bus_rd && sel_data && (rx_count_q != '0);

        tx_wp_d    = tx_push ? tx_wp_q + TX_PW'(1) : tx_wp_q;
        tx_rp_d    = tx_pop  ? tx_rp_q + TX_PW'(1) : tx_rp_q;
        tx_count_d = tx_count_q + TX_CW'(tx_push) - TX_CW'(tx_pop);
        rx_wp_d    = rx_push ? rx_wp_q + RX_PW'(1) : rx_wp_q;
        rx_rp_d    = rx_pop  ? rx_rp_q + RX_PW'(1) : rx_rp_q;
        rx_count_d = rx_count_q + RX_CW'(rx_push) - RX_CW'(rx_pop);

        gap_cnt_d = gap_cnt_q;
        if (tx_pop) begin
            gap_cnt_d = GAP_LOAD;
        end else if (gap_cnt_q != '0) begin
            gap_cnt_d = gap_cnt_q - GW'(1);
        end

        drop_cnt_d = drop_cnt_q;
        if (bus_wr && sel_data && !tx_push && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end

        prog_end_d = prog_end_q || (bus_wr && sel_ctrl);
        io_full_d  = tx_count_d >= TX_ALMOST;

        mem_dout_d = mem_dout_q;
        if (bus_rd) begin
            if (!is_io) begin
                mem_dout_d = ram[ram_idx];
            end else if (sel_data) begin
                mem_dout_d = (rx_count_q != '0) ? rx_mem[rx_rp_q] : 8'h00;
            end else if (sel_ctrl) begin
                mem_dout_d = {6'b0, rx_count_q != '0, tx_count_q == TX_FULL};
            end else begin
                mem_dout_d = 8'h00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            tx_count_q <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            rx_count_q <= '0;
            gap_cnt_q  <= '0;
            mem_dout_q <= 8'h00;
            drop_cnt_q <= 8'h00;
            prog_end_q <= 1'b0;
            io_full_q  <= 1'b0;
        end else begin
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            tx_count_q <= tx_count_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            rx_count_q <= rx_count_d;
            gap_cnt_q  <= gap_cnt_d;
            mem_dout_q <= mem_dout_d;
            drop_cnt_q <= drop_cnt_d;
            prog_end_q <= prog_end_d;
            io_full_q  <= io_full_d;
        end
    end

    // Storage arrays carry no reset; occupancy is tracked solely by the counts above
    always_ff @(posedge clk) begin
        if (!rst && bus_wr && !is_io) begin
            ram[ram_idx] <= bus.mem_din;
        end
        if (tx_push) begin
            tx_mem[tx_wp_q] <= bus.mem_din;
        end
        if (rx_push) begin
            rx_mem[rx_wp_q] <= bus.rx_byte;
        end
    end

    assign bus.mem_dout       = mem_dout_q;
    assign bus.io_buffer_full = io_full_q;
    assign bus.tx_byte        = tx_mem[tx_rp_q];
    assign bus.tx_valid       = tx_valid;
    assign bus.rx_ready       = rx_ready;
    assign bus.prog_end       = prog_end_q;
    assign bus.drop_cnt       = drop_cnt_q;
endmodule
